// File: rtl/mpt_pkg.sv
// Shared types and limits for the PLB port arbiter.
// Requester index type and the default in-flight limit.
package mpt_pkg;

    localparam int MPT_MAX_REQ         = 8;
    localparam int MPT_IDX_W           = 3;
    localparam int MPT_MAX_OUTSTANDING = 4;

    typedef logic [MPT_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/plb_id_fifo.sv
// In-order FIFO of requester indices for granted transactions.
// Pointers wrap modulo DEPTH; occupancy is kept in its own counter.
module plb_id_fifo
    import mpt_pkg::*;
#(
    parameter int DEPTH = MPT_MAX_OUTSTANDING,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  req_idx_t      push_id,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output req_idx_t      head
);

    req_idx_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy update; push is refused while full.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/plb_port_arbiter.sv
// Round-robin arbiter muxing N memory requesters onto one PLB master.
// Responses return in order and are routed by an ID FIFO.
module plb_port_arbiter
    import mpt_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = MPT_MAX_OUTSTANDING,
    localparam int CW             = $clog2(MAX_OUTSTANDING) + 1,
    localparam int BW             = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_mem_req,
    output logic [NUM_REQ-1:0]            req_mem_gnt,
    output logic [NUM_REQ-1:0]            req_mem_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_mem_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_mem_wdata,
    output logic [NUM_REQ*DATA_WIDTH-1:0] req_mem_rdata,
    input  logic [NUM_REQ-1:0]            req_mem_we,
    input  logic [NUM_REQ*BW-1:0]         req_mem_be,
    output logic [NUM_REQ-1:0]            req_mem_error,
    output logic                          plb_master_mem_req,
    input  logic                          plb_master_mem_gnt,
    input  logic                          plb_master_mem_valid,
    output logic [ADDR_WIDTH-1:0]         plb_master_mem_addr,
    input  logic [DATA_WIDTH-1:0]         plb_master_mem_rdata,
    output logic [DATA_WIDTH-1:0]         plb_master_mem_wdata,
    output logic                          plb_master_mem_we,
    output logic [BW-1:0]                 plb_master_mem_be,
    input  logic                          plb_master_mem_error,
    output logic [CW-1:0]                 outstanding_o,
    output logic                          spurious_rsp_o
);

    req_idx_t               ptr;
    req_idx_t               ptr_nxt;
    req_idx_t               winner;
    req_idx_t               head;
    logic [MPT_IDX_W:0]     cand;
    logic [MPT_MAX_REQ-1:0] req_ext;
    logic                   any_req;
    logic                   full;
    logic                   empty;
    logic                   grant_acc;
    logic                   pop;

    assign req_ext   = MPT_MAX_REQ'(req_mem_req);
    assign any_req   = |req_mem_req;
    assign plb_master_mem_req = rst_ni & any_req & ~full;
    assign grant_acc = plb_master_mem_req & plb_master_mem_gnt;
    assign pop       = rst_ni & plb_master_mem_valid & ~empty;

    // Winner search: scan offsets high to low so the nearest one wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (MPT_IDX_W + 1)'(i);
            if (cand >= (MPT_IDX_W + 1)'(NUM_REQ))
                cand = cand - (MPT_IDX_W + 1)'(NUM_REQ);
            if (req_ext[cand[MPT_IDX_W-1:0]])
                winner = cand[MPT_IDX_W-1:0];
        end
    end

    // Forward the winner's command; idle bus is all zeros.
    always_comb begin
        plb_master_mem_addr  = '0;
        plb_master_mem_wdata = '0;
        plb_master_mem_we    = 1'b0;
        plb_master_mem_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (any_req && winner == req_idx_t'(i)) begin
                plb_master_mem_addr  = req_mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                plb_master_mem_wdata = req_mem_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                plb_master_mem_we    = req_mem_we[i];
                plb_master_mem_be    = req_mem_be[i*BW +: BW];
            end
        end
    end

    // Per-requester grant and response strobes.
    always_comb begin
        req_mem_gnt   = '0;
        req_mem_valid = '0;
        req_mem_error = '0;
        req_mem_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_mem_gnt[i]   = grant_acc && (winner == req_idx_t'(i));
            req_mem_valid[i] = pop && (head == req_idx_t'(i));
            req_mem_error[i] = req_mem_valid[i] & plb_master_mem_error;
            if (req_mem_valid[i])
                req_mem_rdata[i*DATA_WIDTH +: DATA_WIDTH] = plb_master_mem_rdata;
        end
    end

    // Pointer moves just past the accepted winner.
    always_comb begin
        ptr_nxt = winner + 1'b1;
        if (winner == req_idx_t'(NUM_REQ - 1)) ptr_nxt = '0;
    end

    // Priority pointer holds while a grant is stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)        ptr <= '0;
        else if (grant_acc) ptr <= ptr_nxt;
    end

    // Sticky flag for a response with nothing in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)                           spurious_rsp_o <= 1'b0;
        else if (plb_master_mem_valid && empty) spurious_rsp_o <= 1'b1;
    end

    plb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (grant_acc),
        .push_id (winner),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .count   (outstanding_o),
        .head    (head)
    );

endmodule

// File: tb/tb_plb_port_arbiter.sv
// Self-checking bench for plb_port_arbiter.
// Directed scenarios plus a random run against a queue-based model.
module tb_plb_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    vld_o;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N*DW-1:0] rdata_o;
    logic [N-1:0]    we;
    logic [N*BW-1:0] be;
    logic [N-1:0]    err_o;
    logic            plb_req;
    logic            plb_gnt;
    logic            plb_valid;
    logic [AW-1:0]   plb_addr;
    logic [DW-1:0]   plb_rdata;
    logic [DW-1:0]   plb_wdata;
    logic            plb_we;
    logic [BW-1:0]   plb_be;
    logic            plb_err;
    logic [CW-1:0]   outstanding;
    logic            spur;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              m_ptr;
    int              m_q[$];
    bit              m_spur;
    int              e_win;
    bit              e_preq;
    logic [N-1:0]    e_gnt;
    logic [N-1:0]    e_vld;
    logic [N*DW-1:0] e_rdata;
    logic [AW-1:0]   e_addr;

    always #5 clk = ~clk;

    plb_port_arbiter #(
        .NUM_REQ         (N),
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .req_mem_req          (req),
        .req_mem_gnt          (gnt_o),
        .req_mem_valid        (vld_o),
        .req_mem_addr         (addr),
        .req_mem_wdata        (wdata),
        .req_mem_rdata        (rdata_o),
        .req_mem_we           (we),
        .req_mem_be           (be),
        .req_mem_error        (err_o),
        .plb_master_mem_req   (plb_req),
        .plb_master_mem_gnt   (plb_gnt),
        .plb_master_mem_valid (plb_valid),
        .plb_master_mem_addr  (plb_addr),
        .plb_master_mem_rdata (plb_rdata),
        .plb_master_mem_wdata (plb_wdata),
        .plb_master_mem_we    (plb_we),
        .plb_master_mem_be    (plb_be),
        .plb_master_mem_error (plb_err),
        .outstanding_o        (outstanding),
        .spurious_rsp_o       (spur)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        plb_gnt   = 1'b0;
        plb_valid = 1'b0;
        plb_rdata = '0;
        plb_err   = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Expected combinational outputs from the current model state.
    function automatic void model_eval();
        e_win = -1;
        for (int k = 0; k < N; k++) begin
            int r;
            r = (m_ptr + k) % N;
            if (e_win < 0 && req[r]) e_win = r;
        end
        e_preq  = rst_n && (e_win >= 0) && (m_q.size() < MO);
        e_gnt   = '0;
        e_vld   = '0;
        e_rdata = '0;
        e_addr  = '0;
        if (e_win >= 0) e_addr = addr[e_win*AW +: AW];
        if (e_preq && plb_gnt) e_gnt[e_win] = 1'b1;
        if (rst_n && plb_valid && m_q.size() > 0) begin
            e_vld[m_q[0]] = 1'b1;
            e_rdata[m_q[0]*DW +: DW] = plb_rdata;
        end
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_commit();
        if (!rst_n) begin
            m_ptr  = 0;
            m_q.delete();
            m_spur = 1'b0;
        end else begin
            if (plb_valid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_spur = 1'b1;
            end
            if (e_preq && plb_gnt) begin
                m_q.push_back(e_win);
                m_ptr = (e_win + 1) % N;
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req = '1; plb_gnt = 1'b1; plb_valid = 1'b1;
        #1;
        checks++; if (gnt_o !== '0) begin errors++; $display("FAIL rst_gnt got %b exp 0", gnt_o); end
        checks++; if (vld_o !== '0) begin errors++; $display("FAIL rst_vld got %b exp 0", vld_o); end
        checks++; if (plb_req !== 1'b0) begin errors++; $display("FAIL rst_plbreq got %b exp 0", plb_req); end
        tick();
        checks++; if (outstanding !== '0) begin errors++; $display("FAIL rst_outst got %0d exp 0", outstanding); end
        checks++; if (spur !== 1'b0) begin errors++; $display("FAIL rst_spur got %b exp 0", spur); end
        do_reset();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp;
        do_reset();
        req = 4'b0011; plb_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp = (c % 2 == 0) ? 4'b0001 : 4'b0010;
            checks++; if (gnt_o !== exp) begin errors++; $display("FAIL fair_gnt%0d got %b exp %b", c, gnt_o, exp); end
            tick();
        end
        req = '0; plb_gnt = 1'b0;
        #1;
        checks++; if (outstanding !== CW'(4)) begin errors++; $display("FAIL fair_outst got %0d exp 4", outstanding); end
    endtask

    task automatic test_stall();
        do_reset();
        req = 4'b0010; plb_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (gnt_o !== '0 || plb_req !== 1'b1) begin errors++; $display("FAIL stall%0d gnt %b req %b exp 0000/1", c, gnt_o, plb_req); end
            tick();
            checks++; if (outstanding !== '0) begin errors++; $display("FAIL stall_outst%0d got %0d exp 0", c, outstanding); end
        end
        plb_gnt = 1'b1;
        #1;
        checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL stall_gnt got %b exp 0010", gnt_o); end
        tick();
        req = '0; plb_gnt = 1'b0;
        #1;
        checks++; if (outstanding !== CW'(1)) begin errors++; $display("FAIL stall_outst got %0d exp 1", outstanding); end
    endtask

    task automatic test_routing();
        logic [DW-1:0]   vals [3];
        int              tgt  [3];
        logic [N*DW-1:0] exp_rd;
        vals[0] = 32'hAAAA_0001; vals[1] = 32'hBBBB_0002; vals[2] = 32'hCCCC_0003;
        tgt[0] = 0; tgt[1] = 1; tgt[2] = 0;
        do_reset();
        req = 4'b0011; plb_gnt = 1'b1;
        tick(); tick(); tick();
        req = '0; plb_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            plb_valid = 1'b1; plb_rdata = vals[c];
            #1;
            exp_rd = '0;
            exp_rd[tgt[c]*DW +: DW] = vals[c];
            checks++; if (vld_o !== (4'b0001 << tgt[c])) begin errors++; $display("FAIL route_vld%0d got %b exp req%0d", c, vld_o, tgt[c]); end
            checks++; if (rdata_o !== exp_rd) begin errors++; $display("FAIL route_rd%0d got %h exp %h", c, rdata_o, exp_rd); end
            tick();
        end
        plb_valid = 1'b0;
        #1;
        checks++; if (outstanding !== '0) begin errors++; $display("FAIL route_outst got %0d exp 0", outstanding); end
    endtask

    task automatic test_full();
        do_reset();
        req = 4'b0011; plb_gnt = 1'b1;
        tick(); tick(); tick(); tick();
        #1;
        checks++; if (plb_req !== 1'b0 || gnt_o !== '0) begin errors++; $display("FAIL full_block req %b gnt %b exp 0/0000", plb_req, gnt_o); end
        checks++; if (outstanding !== CW'(4)) begin errors++; $display("FAIL full_outst got %0d exp 4", outstanding); end
        plb_valid = 1'b1; plb_rdata = 32'h1234_5678;
        #1;
        checks++; if (plb_req !== 1'b0) begin errors++; $display("FAIL full_popcycle req %b exp 0", plb_req); end
        tick();
        plb_valid = 1'b0;
        #1;
        checks++; if (plb_req !== 1'b1) begin errors++; $display("FAIL full_reassert req %b exp 1", plb_req); end
        checks++; if (outstanding !== CW'(3)) begin errors++; $display("FAIL full_outst3 got %0d exp 3", outstanding); end
    endtask

    task automatic test_spurious();
        do_reset();
        plb_valid = 1'b1; plb_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (vld_o !== '0) begin errors++; $display("FAIL spur_vld got %b exp 0", vld_o); end
        tick();
        plb_valid = 1'b0;
        #1;
        checks++; if (spur !== 1'b1) begin errors++; $display("FAIL spur_set got %b exp 1", spur); end
        tick(); tick();
        checks++; if (spur !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", spur); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = 32'h5000_0000 + 32'(i);
        do_reset();
        req = 4'b0110; plb_gnt = 1'b1;
        tick(); tick();
        req = '0; plb_gnt = 1'b0;
        #1;
        checks++; if (outstanding !== CW'(2)) begin errors++; $display("FAIL mid_pre got %0d exp 2", outstanding); end
        rst_n = 1'b0; req = 4'b1111; plb_gnt = 1'b1;
        #1;
        checks++; if (gnt_o !== '0 || plb_req !== 1'b0) begin errors++; $display("FAIL mid_gate gnt %b req %b exp 0", gnt_o, plb_req); end
        tick();
        rst_n = 1'b1; plb_gnt = 1'b0;
        #1;
        checks++; if (outstanding !== '0) begin errors++; $display("FAIL mid_outst got %0d exp 0", outstanding); end
        checks++; if (plb_addr !== 32'h5000_0000) begin errors++; $display("FAIL mid_ptr addr %h exp 50000000", plb_addr); end
        req = '0; plb_valid = 1'b1;
        tick();
        plb_valid = 1'b0;
        #1;
        checks++; if (spur !== 1'b1) begin errors++; $display("FAIL mid_spur got %b exp 1", spur); end
    endtask

    task automatic test_random();
        do_reset();
        m_ptr = 0; m_q.delete(); m_spur = 1'b0;
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) addr[i*AW +: AW] = $urandom;
            plb_gnt   = ($urandom_range(0, 3) != 0);
            plb_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            plb_rdata = $urandom;
            plb_err   = $urandom_range(0, 1);
            #1;
            model_eval();
            checks++; if (plb_req !== e_preq) begin errors++; $display("FAIL rnd_req c%0d got %b exp %b", c, plb_req, e_preq); end
            checks++; if (gnt_o !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %b exp %b", c, gnt_o, e_gnt); end
            checks++; if (vld_o !== e_vld) begin errors++; $display("FAIL rnd_vld c%0d got %b exp %b", c, vld_o, e_vld); end
            checks++; if (err_o !== (plb_err ? e_vld : '0)) begin errors++; $display("FAIL rnd_err c%0d got %b", c, err_o); end
            checks++; if (rdata_o !== e_rdata) begin errors++; $display("FAIL rnd_rd c%0d got %h exp %h", c, rdata_o, e_rdata); end
            checks++; if (plb_addr !== e_addr) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", c, plb_addr, e_addr); end
            checks++; if (outstanding !== CW'(m_q.size())) begin errors++; $display("FAIL rnd_outst c%0d got %0d exp %0d", c, outstanding, m_q.size()); end
            checks++; if (spur !== m_spur) begin errors++; $display("FAIL rnd_spur c%0d got %b exp %b", c, spur, m_spur); end
            @(posedge clk);
            model_commit();
            #1;
        end
        plb_valid = 1'b0; plb_gnt = 1'b0; req = '0;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; plb_gnt = 1'b0; plb_valid = 1'b0;
        plb_rdata = '0; plb_err = 1'b0; we = '0; be = '1; wdata = '0;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = 32'hA000_0000 + 32'(i);
        tick();
        test_reset();
        test_fairness();
        test_stall();
        test_routing();
        test_full();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
